// File: rtl/ped_request_ctrl.sv
// Pedestrian crossing request controller.
// Latches button presses, holds traffic at Red and sequences walk / clear / cooldown.
module ped_request_ctrl #(
    parameter int unsigned WALK_CYCLES     = 8,
    parameter int unsigned CLEAR_CYCLES    = 4,
    parameter int unsigned COOLDOWN_CYCLES = 6
) (
    input  logic       clk_main,
    input  logic       rst_main_n,
    input  logic       ped_btn,
    input  logic [1:0] traffic_light,
    output logic       hold_red,
    output logic       walk,
    output logic       dont_walk_flash,
    output logic [7:0] walk_count,
    output logic       ped_pending,
    output logic       fault
);

    localparam logic [7:0] WALK_LD  = 8'(WALK_CYCLES - 1);
    localparam logic [7:0] CLEAR_LD = 8'(CLEAR_CYCLES - 1);
    localparam logic [7:0] COOL_LD  = 8'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WALK,
        S_CLEAR,
        S_COOL
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       btn_q;
    logic       flash_q, flash_d;
    logic       pend_d, fault_d;

    logic       rise;
    logic       red;
    logic       cnt_zero;
    logic [7:0] cnt_dec;

    assign rise     = ped_btn & ~btn_q;
    assign red      = (traffic_light == 2'b10);
    assign cnt_zero = (cnt_q == 8'd0);
    assign cnt_dec  = cnt_zero ? cnt_q : cnt_q - 8'd1;

    // State, counter and flag registers; reset abandons any crossing.
    always_ff @(posedge clk_main or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            btn_q       <= 1'b0;
            flash_q     <= 1'b0;
            ped_pending <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_q       <= ped_btn;
            flash_q     <= flash_d;
            ped_pending <= pend_d;
            fault       <= fault_d;
        end
    end

    // Next-state: request latching, phase sequencing and Red-loss detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        pend_d  = ped_pending;
        fault_d = fault;
        unique case (state_q)
            S_IDLE: begin
                if (rise) pend_d = 1'b1;
                if (ped_pending || rise) state_d = S_REQ;
            end
            S_REQ: begin
                if (rise) pend_d = 1'b1;
                if (red) begin
                    state_d = S_WALK;
                    cnt_d   = WALK_LD;
                    pend_d  = 1'b0;
                end
            end
            S_WALK: begin
                if (!red || cnt_zero) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LD;
                    flash_d = 1'b1;
                    if (!red) fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_CLEAR: begin
                if (!red) fault_d = 1'b1;
                flash_d = ~flash_q;
                if (cnt_zero) begin
                    state_d = S_COOL;
                    cnt_d   = COOL_LD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_COOL: begin
                if (rise) pend_d = 1'b1;
                if (cnt_zero) state_d = S_IDLE;
                else cnt_d = cnt_dec;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lamp and request outputs decoded purely from registers.
    always_comb begin
        hold_red        = (state_q == S_REQ) || (state_q == S_WALK)
                          || (state_q == S_CLEAR);
        walk            = (state_q == S_WALK);
        walk_count      = (state_q == S_WALK) ? cnt_q : 8'd0;
        dont_walk_flash = (state_q == S_CLEAR) && flash_q;
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Testbench for ped_request_ctrl.
// Scenario tasks plus randomized traffic against a phase/elapsed-time reference model.
module tb_ped_request_ctrl;

    localparam int WC = 8;
    localparam int CC = 4;
    localparam int KC = 6;

    logic       clk_main = 1'b0;
    logic       rst_main_n;
    logic       ped_btn;
    logic [1:0] traffic_light;
    logic       hold_red;
    logic       walk;
    logic       dont_walk_flash;
    logic [7:0] walk_count;
    logic       ped_pending;
    logic       fault;

    ped_request_ctrl #(
        .WALK_CYCLES    (WC),
        .CLEAR_CYCLES   (CC),
        .COOLDOWN_CYCLES(KC)
    ) dut (
        .clk_main       (clk_main),
        .rst_main_n     (rst_main_n),
        .ped_btn        (ped_btn),
        .traffic_light  (traffic_light),
        .hold_red       (hold_red),
        .walk           (walk),
        .dont_walk_flash(dont_walk_flash),
        .walk_count     (walk_count),
        .ped_pending    (ped_pending),
        .fault          (fault)
    );

    always #5 clk_main = ~clk_main;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 request, 2 walk, 3 clear, 4 cooldown;
    // m_el counts cycles already spent in the current phase.
    int   m_ph;
    int   m_el;
    bit   m_pend;
    bit   m_fault;
    bit   m_prev;
    logic hr_d;
    logic walk_prev;
    int   crossings;

    function automatic logic [12:0] dut_vec();
        return {hold_red, walk, dont_walk_flash, walk_count, ped_pending, fault};
    endfunction

    function automatic logic [12:0] model_vec();
        logic [7:0] wc;
        logic       hr;
        logic       fl;
        wc = (m_ph == 2) ? 8'(WC - 1 - m_el) : 8'd0;
        hr = (m_ph >= 1 && m_ph <= 3);
        fl = (m_ph == 3) && (m_el % 2 == 0);
        return {hr, logic'(m_ph == 2), fl, wc, logic'(m_pend), logic'(m_fault)};
    endfunction

    function automatic logic [1:0] fol();
        return hr_d ? 2'b10 : 2'b00;
    endfunction

    task automatic model_reset();
        m_ph      = 0;
        m_el      = 0;
        m_pend    = 0;
        m_fault   = 0;
        m_prev    = 0;
        hr_d      = 1'b0;
        walk_prev = 1'b0;
    endtask

    task automatic model_step(input logic btn, input logic [1:0] light);
        bit rise;
        bit red;
        rise   = btn && !m_prev;
        m_prev = btn;
        red    = (light == 2'b10);
        case (m_ph)
            0: begin
                if (rise) m_pend = 1;
                if (m_pend) begin m_ph = 1; m_el = 0; end
            end
            1: begin
                if (rise) m_pend = 1;
                if (red) begin m_ph = 2; m_el = 0; m_pend = 0; end
            end
            2: begin
                if (!red) begin m_fault = 1; m_ph = 3; m_el = 0; end
                else if (m_el == WC - 1) begin m_ph = 3; m_el = 0; end
                else m_el++;
            end
            3: begin
                if (!red) m_fault = 1;
                if (m_el == CC - 1) begin m_ph = 4; m_el = 0; end
                else m_el++;
            end
            default: begin
                if (rise) m_pend = 1;
                if (m_el == KC - 1) begin m_ph = 0; m_el = 0; end
                else m_el++;
            end
        endcase
    endtask

    task automatic cyc(input logic btn, input logic [1:0] light);
        ped_btn       = btn;
        traffic_light = light;
        @(posedge clk_main);
        model_step(btn, light);
        @(negedge clk_main);
        hr_d = hold_red;
        if (walk === 1'b1 && walk_prev !== 1'b1) crossings++;
        walk_prev = walk;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (dut_vec() !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_async: got %h want %h", dut_vec(), 13'd0);
        end
        @(negedge clk_main);
        n_cmp++;
        if (dut_vec() !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_held: got %h want %h", dut_vec(), 13'd0);
        end
        #2 rst_main_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, fol());
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL reset_idle c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_basic();
        int         walk_hi = 0;
        int         k = -1;
        logic [3:0] seq = 4'd0;
        logic       pw;
        crossings = 0;
        cyc(1'b1, fol());
        n_cmp++;
        if (hold_red !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_hold_t1: got %b want 1", hold_red);
        end
        for (int i = 0; i < 30; i++) begin
            pw = walk;
            cyc(1'b0, fol());
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL basic c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (walk === 1'b1) walk_hi++;
            if (k < 0 && pw === 1'b1 && walk === 1'b0) k = 0;
            if (k >= 0 && k < 4) begin
                seq = {seq[2:0], dont_walk_flash};
                k++;
            end
        end
        n_cmp++;
        if (walk_hi != WC) begin
            n_bad++;
            $display("FAIL basic_walk_len: got %0d want %0d", walk_hi, WC);
        end
        n_cmp++;
        if (seq !== 4'b1010) begin
            n_bad++;
            $display("FAIL basic_flash_seq: got %b want 1010", seq);
        end
        n_cmp++;
        if (crossings != 1) begin
            n_bad++;
            $display("FAIL basic_crossings: got %0d want 1", crossings);
        end
    endtask

    task automatic test_press_walk();
        bit   p1 = 0;
        bit   p2 = 0;
        logic b;
        crossings = 0;
        cyc(1'b1, fol());
        for (int i = 0; i < 60; i++) begin
            b = 1'b0;
            if (!p1 && m_ph == 2 && m_el == 2) begin
                b  = 1'b1;
                p1 = 1;
            end else if (!p2 && m_ph == 4 && m_el == 1) begin
                b  = 1'b1;
                p2 = 1;
            end
            cyc(b, fol());
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL press_walk c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (b === 1'b1) begin
                n_cmp++;
                if (ped_pending !== logic'(p2)) begin
                    n_bad++;
                    $display("FAIL press_walk_pending: got %b want %b", ped_pending, p2);
                end
            end
        end
        n_cmp++;
        if (!(p1 && p2) || crossings != 2) begin
            n_bad++;
            $display("FAIL press_walk_crossings: got %0d want 2 (p1=%0d p2=%0d)",
                     crossings, p1, p2);
        end
    endtask

    task automatic test_held();
        crossings = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(logic'(i < 40), fol());
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL held c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (crossings != 1 || ped_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL held_once: got %0d/%b want 1/0", crossings, ped_pending);
        end
    endtask

    task automatic test_red_delay();
        cyc(1'b1, 2'b00);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 2'b00);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL red_delay c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if ({hold_red, walk} !== 2'b10) begin
            n_bad++;
            $display("FAIL red_delay_wait: got %b want 10", {hold_red, walk});
        end
        cyc(1'b0, 2'b10);
        n_cmp++;
        if (walk !== 1'b1) begin
            n_bad++;
            $display("FAIL red_delay_walk: got %b want 1", walk);
        end
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, fol());
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL red_tail c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_walk_abort();
        int guard = 0;
        cyc(1'b1, fol());
        while (!(m_ph == 2 && m_el == 2) && guard < 20) begin
            cyc(1'b0, fol());
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_bad++;
            $display("FAIL abort_timeout: got %0d cycles want <20", guard);
        end
        cyc(1'b0, 2'b00);
        n_cmp++;
        if ({walk, dont_walk_flash, fault} !== 3'b011) begin
            n_bad++;
            $display("FAIL abort_clear: got %b want 011", {walk, dont_walk_flash, fault});
        end
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, fol());
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL abort c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_sticky: got %b want 1", fault);
        end
    endtask

    task automatic test_reset_mid_walk();
        int guard = 0;
        cyc(1'b1, fol());
        while (!(m_ph == 2 && m_el == 4) && guard < 20) begin
            cyc(1'b0, fol());
            guard++;
        end
        rst_main_n = 1'b0;
        ped_btn    = 1'b0;
        #1;
        n_cmp++;
        if (guard >= 20 || dut_vec() !== 13'd0) begin
            n_bad++;
            $display("FAIL rst_walk_async: got %h want %h (guard %0d)",
                     dut_vec(), 13'd0, guard);
        end
        model_reset();
        @(posedge clk_main);
        @(negedge clk_main);
        #2 rst_main_n = 1'b1;
        crossings = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, fol());
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL rst_walk c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (crossings != 0) begin
            n_bad++;
            $display("FAIL rst_walk_nocross: got %0d want 0", crossings);
        end
    endtask

    task automatic test_random();
        logic       b = 1'b0;
        logic [1:0] l;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_main_n = 1'b0;
                b          = 1'b0;
                ped_btn    = 1'b0;
                #1;
                n_cmp++;
                if (dut_vec() !== 13'd0) begin
                    n_bad++;
                    $display("FAIL rand_reset c%0d: got %h want %h", i, dut_vec(), 13'd0);
                end
                model_reset();
                @(posedge clk_main);
                @(negedge clk_main);
                #2 rst_main_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) b = ~b;
            l = fol();
            if ($urandom_range(0, 49) == 0) l = 2'($urandom_range(0, 3));
            cyc(b, l);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL rand c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        rst_main_n    = 1'b0;
        ped_btn       = 1'b0;
        traffic_light = 2'b00;
        crossings     = 0;
        model_reset();
        test_reset();
        test_basic();
        test_press_walk();
        test_held();
        test_red_delay();
        test_walk_abort();
        test_reset_mid_walk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ped_request_ctrl.md
PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 Parameter WALK_CYCLES, default 8, walk-phase length in clk_main cycles (legal range 1..255).
REQ-002 Parameter CLEAR_CYCLES, default 4, flashing don't-walk phase length in cycles (legal range 1..255).
REQ-003 Parameter COOLDOWN_CYCLES, default 6, minimum hold_red-low time between crossings (legal range 1..255).
REQ-004 clk_main  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_main_n  input  1  reset, asynchronous, active-low.
REQ-006 ped_btn  input  1  pedestrian button level, already synchronous to clk_main.
REQ-007 traffic_light  input  2  light state from the traffic controller: 00 = Green, 01 = Yellow, 10 = Red, 11 = illegal and treated as not Red.
REQ-008 hold_red  output  1  request that forces and holds the traffic controller at Red.
REQ-009 walk  output  1  walk lamp.
REQ-010 dont_walk_flash  output  1  flashing don't-walk lamp.
REQ-011 walk_count  output  8  remaining walk cycles, for the countdown display.
REQ-012 ped_pending  output  1  a button press is latched and not yet served.
REQ-013 fault  output  1  sticky flag: Red was lost while pedestrians had right of way.

Function
REQ-014 The FSM shall have the states IDLE, REQ, WALK, CLEAR and COOLDOWN. All outputs shall be registered or decoded only from registers.
REQ-015 Button rise shall be detected as ped_btn=1 while its previous-cycle registered value is 0; a held button shall produce exactly one rise.
REQ-016 A rise in IDLE, REQ or COOLDOWN shall set ped_pending at the next edge; a rise in WALK or CLEAR shall be ignored.
REQ-017 IDLE->REQ shall occur on the edge where ped_pending=1 or a rise is detected, so hold_red goes to 1 one cycle after the sampled rise.
REQ-018 hold_red shall be 1 in REQ, WALK and CLEAR, and 0 in IDLE and COOLDOWN.
REQ-019 REQ->WALK shall occur on the edge where traffic_light==10. REQ shall have no timeout.
REQ-020 On entry to WALK: ped_pending shall be cleared, and the counter shall be loaded with WALK_CYCLES-1.
REQ-021 In WALK: walk=1, walk_count=counter, and the counter shall decrement each cycle. WALK->CLEAR shall occur on the edge where counter==0, so walk is high exactly WALK_CYCLES cycles.
REQ-022 On entry to CLEAR, the counter shall be loaded with CLEAR_CYCLES-1.
REQ-023 In CLEAR: dont_walk_flash shall be 1 in the first cycle and toggle every cycle after. CLEAR->COOLDOWN shall occur at counter==0, so CLEAR lasts exactly CLEAR_CYCLES cycles.
REQ-024 COOLDOWN shall load COOLDOWN_CYCLES-1 and last exactly COOLDOWN_CYCLES cycles, then go to IDLE.
REQ-025 If ped_pending=1 on arrival in IDLE, IDLE->REQ shall follow on the next edge.
REQ-026 In every state other than WALK, walk=0 and walk_count=0. In every state other than CLEAR, dont_walk_flash=0.
REQ-027 If traffic_light!=10 during WALK, the next edge shall force CLEAR (full CLEAR_CYCLES) and set fault=1.
REQ-028 If traffic_light!=10 during CLEAR, fault shall be set and the CLEAR sequence shall continue unchanged.
REQ-029 fault shall clear only on reset.
REQ-030 A rise and WALK entry in the same cycle shall not set ped_pending, because the rise is ignored per REQ-016.
REQ-031 Counters shall be 8 bits and shall not wrap: decrement happens only while counter>0.

Reset
REQ-032 While rst_main_n=0, all outputs shall be held immediately at: state=IDLE, hold_red=0, walk=0, dont_walk_flash=0, walk_count=0, ped_pending=0, fault=0, counter=0, previous-button register=0.
REQ-033 Reset asserted mid-WALK or mid-CLEAR shall abandon the crossing with no residual pending request. The first edge after deassertion shall evaluate from IDLE.

Verification
REQ-034 Defaults; pulse ped_btn 1 cycle at t0; traffic_light follows hold_red (Red 1 cycle after hold_red=1) -> hold_red=1 at t0+1; walk=1 for exactly 8 cycles with walk_count 7..0; dont_walk_flash 1,0,1,0; hold_red=0 for 6 cycles, then IDLE.
REQ-035 Press during WALK, then a second press during COOLDOWN -> the first is ignored; ped_pending=1 after the second; REQ re-entered on the first IDLE cycle; exactly one more crossing.
REQ-036 ped_btn held high for 40 cycles -> exactly one crossing; ped_pending=0 after WALK entry.
REQ-037 traffic_light held at 00 for 10 cycles after the request -> FSM stays in REQ with hold_red=1 and walk=0; walk=1 one cycle after traffic_light becomes 10.
REQ-038 traffic_light driven to 00 at the 3rd WALK cycle -> walk=0 and CLEAR entered next cycle, fault=1 and remaining set until reset.
REQ-039 rst_main_n pulsed low at the 5th WALK cycle -> all outputs 0 immediately; no crossing after release without a new press.
